lsu_mem_stage: RTL
==================

Name: lsu_mem_stage

Overview:
- MEM-stage load/store unit of the 5-stage RV64 core.
- Sits between ex_mem_reg (upstream) and mem_wb_reg (downstream).
- Consumes the held EX/MEM bundle and drives the data-memory req/gnt/rvalid port.
- Produces the aligned, extended load data plus a one-cycle completion strobe that mem_wb_reg captures. Stalls upstream through in_ready.

Parameters:
ADDR_W, 32, data-memory address width; dmem_addr = exu_result[ADDR_W-1:3], 8-byte aligned.
TIMEOUT_CYC, 255, bus timeout in cycles while waiting for gnt or rvalid; 0 disables the timeout.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
in_valid  in  1  EX/MEM bundle valid, held until in_ready
in_ready  out  1  stage accepts/retires current bundle this cycle
in_pc  in  32  PC
in_inst  in  32  instruction
in_rd  in  5  destination register
in_rd_w_en  in  1  register write enable
in_mem_r_en  in  1  load
in_mem_w_en  in  1  store (never set together with in_mem_r_en)
in_funct3  in  3  size/sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
in_exu_result  in  64  effective address, or ALU result
in_x_rs2  in  64  store data
dmem_req  out  1  request
dmem_we  out  1  1 = write
dmem_addr  out  ADDR_W-3  doubleword address
dmem_wdata  out  64  lane-shifted store data
dmem_wstrb  out  8  byte strobes
dmem_gnt  in  1  request accepted
dmem_rvalid  in  1  read data valid
dmem_rdata  in  64  read doubleword
out_valid  out  1  one-cycle completion strobe to mem_wb_reg
out_pc, out_inst, out_rd, out_exu_result  out  32/32/5/64  pass-through of the held bundle
out_rd_w_en  out  1  in_rd_w_en & ~out_misalign & ~out_bus_err
out_lsu_r_data  out  64  extended load data; 0 for non-loads
out_misalign  out  1  misaligned access, flagged with out_valid
out_bus_err  out  1  timeout, flagged with out_valid

Behaviour:
- State machine: IDLE, WAIT_R. Timeout counter cnt has width ceil(log2(TIMEOUT_CYC+1)).
- Reset (rst=0, asynchronous): state=IDLE, cnt=0.
- While rst=0, out_valid, dmem_req and in_ready are all 0. Flags and data outputs are 0 when out_valid=0.
- Offset: off = in_exu_result[2:0].
- Misalignment rules:
  - H/HU misaligned if off[0].
  - W/WU misaligned if off[1:0]!=0.
  - D misaligned if off!=0.
  - funct3 111 is treated as D.
- Non-memory bundle (in_valid & ~r_en & ~w_en):
  - out_valid=in_ready=1 in the same cycle (latency 0).
  - No bus activity.
- Misaligned load or store:
  - Same-cycle completion with out_misalign=1.
  - dmem_req is never raised.
- Store, IDLE, aligned:
  - dmem_req=1, dmem_we=1.
  - dmem_wstrb = {1,3,0F,FF}[size] << off.
  - dmem_wdata = in_x_rs2 << (8*off).
  - Request is held stable until dmem_gnt. On the gnt cycle out_valid=in_ready=1; state stays IDLE.
- Load, IDLE, aligned:
  - dmem_req=1, dmem_we=0, dmem_wstrb=0.
  - On gnt: state moves to WAIT_R and dmem_req drops.
  - In WAIT_R: on dmem_rvalid, out_valid=in_ready=1 and state returns to IDLE.
  - out_lsu_r_data = (dmem_rdata >> 8*off), truncated to the access size, then sign-extended (B/H/W) or zero-extended (BU/HU/WU). Data is combinational from dmem_rdata in the rvalid cycle.
- Bus timing rules:
  - rvalid arrives no earlier than the cycle after gnt.
  - rvalid seen in IDLE is ignored.
  - gnt without req is ignored.
- Timeout:
  - cnt increments each cycle the stage is waiting: IDLE with req & ~gnt, or WAIT_R & ~rvalid. It clears on completion.
  - When cnt reaches TIMEOUT_CYC (and TIMEOUT_CYC≠0): complete with out_bus_err=1, out_lsu_r_data=0, state=IDLE, cnt=0.
  - A late rvalid after a timeout is ignored.
- in_ready = out_valid.
- out_valid never asserts twice for the same bundle: upstream advances on in_ready, so the next cycle presents a new bundle or in_valid=0.
- Reset in WAIT_R drops the outstanding load; a subsequent rvalid is ignored.

Test Plan:
- ALU bundle, in_exu_result=0x1234, in_rd_w_en=1 -> out_valid=1 same cycle, out_rd_w_en=1, dmem_req=0.
- SW, addr=0x80000004, rs2=0xDEADBEEF, gnt after 2 cycles:
  - -> dmem_wstrb=0xF0, dmem_wdata=0xDEADBEEF_00000000, dmem_addr=0x10000000.
  - -> req held 3 cycles; out_valid on the gnt cycle.
- LB, addr=0x80000003, rdata=0x00000000_80000000, gnt then rvalid after 1 cycle -> out_lsu_r_data=0xFFFFFFFFFFFFFF80.
- Same access as LBU -> out_lsu_r_data=0x80.
- LH at addr=0x80000001 -> same-cycle out_valid, out_misalign=1, out_rd_w_en=0, no req.
- LD granted, rvalid withheld, TIMEOUT_CYC=4 -> out_bus_err=1 after 4 waiting cycles; a later rvalid is ignored.
- Reset pulse (rst=0) while in WAIT_R -> out_valid=0, state=IDLE. rvalid at 1 after release -> no out_valid.

Source files
------------

// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit for the 5-stage RV64 core.
// Takes the held EX/MEM bundle and drives the data-memory port.
// Loads and stores complete through a req/gnt/rvalid handshake.
// Produces aligned, extended load data and a one-cycle completion strobe for mem_wb_reg.
//
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   in_*                 EX/MEM bundle (held until in_ready)
//   in_ready             bundle retires this cycle (equals out_valid)
//   dmem_*               data-memory request/grant/read-valid port
//   out_valid            completion strobe; out_* are zero while it is low
//   out_misalign         access was misaligned, no bus activity
//   out_bus_err          bus timed out waiting for gnt or rvalid
module lsu_mem_stage #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_inst,
  input  logic [4:0]        in_rd,
  input  logic              in_rd_w_en,
  input  logic              in_mem_r_en,
  input  logic              in_mem_w_en,
  input  logic [2:0]        in_funct3,
  input  logic [63:0]       in_exu_result,
  input  logic [63:0]       in_x_rs2,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-4:0] dmem_addr,
  output logic [63:0]       dmem_wdata,
  output logic [7:0]        dmem_wstrb,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [63:0]       dmem_rdata,
  output logic              out_valid,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_inst,
  output logic [4:0]        out_rd,
  output logic [63:0]       out_exu_result,
  output logic              out_rd_w_en,
  output logic [63:0]       out_lsu_r_data,
  output logic              out_misalign,
  output logic              out_bus_err
);

  // A zero-width counter is illegal, so the disabled case still keeps one bit.
  localparam int unsigned   CntW   = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYC);

  typedef enum logic [0:0] {StIdle, StWaitR} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [2:0]  off;
  logic [1:0]  size;
  logic        is_mem;
  logic        mis_raw;
  logic [7:0]  strb_base;
  logic [63:0] load_shift;
  logic [63:0] load_ext;
  logic        timeout;

  // Completion events for the current cycle.
  logic fin;
  logic fin_mis;
  logic fin_err;
  logic fin_load;
  logic req;

  // Access decode, lane placement and load extraction.
  always_comb begin
    off        = in_exu_result[2:0];
    size       = in_funct3[1:0];
    is_mem     = in_mem_r_en | in_mem_w_en;
    mis_raw    = 1'b0;
    strb_base  = 8'hFF;
    unique case (size)
      2'b00: begin mis_raw = 1'b0;       strb_base = 8'h01; end
      2'b01: begin mis_raw = off[0];     strb_base = 8'h03; end
      2'b10: begin mis_raw = |off[1:0];  strb_base = 8'h0F; end
      default: begin mis_raw = |off;     strb_base = 8'hFF; end
    endcase
    load_shift = dmem_rdata >> {off, 3'b000};
    case (in_funct3)
      3'b000:  load_ext = {{56{load_shift[7]}}, load_shift[7:0]};
      3'b001:  load_ext = {{48{load_shift[15]}}, load_shift[15:0]};
      3'b010:  load_ext = {{32{load_shift[31]}}, load_shift[31:0]};
      3'b100:  load_ext = {56'd0, load_shift[7:0]};
      3'b101:  load_ext = {48'd0, load_shift[15:0]};
      3'b110:  load_ext = {32'd0, load_shift[31:0]};
      default: load_ext = load_shift;
    endcase
  end

  // Per-cycle events: what completes and whether a request is on the bus.
  always_comb begin
    fin      = 1'b0;
    fin_mis  = 1'b0;
    fin_err  = 1'b0;
    fin_load = 1'b0;
    req      = 1'b0;
    timeout  = (TIMEOUT_CYC != 0) && (cnt_q == CntMax);
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (!is_mem) begin
            fin = 1'b1;
          end else if (mis_raw) begin
            fin     = 1'b1;
            fin_mis = 1'b1;
          end else begin
            req = 1'b1;
            if (dmem_gnt) begin
              fin = in_mem_w_en;
            end else if (timeout) begin
              fin     = 1'b1;
              fin_err = 1'b1;
            end
          end
        end
      end
      StWaitR: begin
        if (dmem_rvalid) begin
          fin      = 1'b1;
          fin_load = 1'b1;
        end else if (timeout) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req && dmem_gnt && in_mem_r_en) begin
          state_d = StWaitR;
        end else if (req && !dmem_gnt && !fin) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitR: begin
        if (fin) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (fin) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs; rst gates the combinational strobes so nothing leaks out during reset.
  always_comb begin
    out_valid      = fin & rst;
    in_ready       = out_valid;
    dmem_req       = req & rst;
    dmem_we        = dmem_req & in_mem_w_en;
    dmem_addr      = in_exu_result[ADDR_W-1:3];
    dmem_wstrb     = dmem_we ? (strb_base << off) : 8'h00;
    dmem_wdata     = dmem_we ? (in_x_rs2 << {off, 3'b000}) : 64'd0;
    out_pc         = out_valid ? in_pc : 32'd0;
    out_inst       = out_valid ? in_inst : 32'd0;
    out_rd         = out_valid ? in_rd : 5'd0;
    out_exu_result = out_valid ? in_exu_result : 64'd0;
    out_misalign   = out_valid & fin_mis;
    out_bus_err    = out_valid & fin_err;
    out_rd_w_en    = out_valid & in_rd_w_en & ~fin_mis & ~fin_err;
    out_lsu_r_data = (out_valid & fin_load) ? load_ext : 64'd0;
  end

endmodule
